// File: rtl/cp0_pkg.sv
// Shared definitions for the coprocessor-0 block: register indices, field
// positions and exception codes.
package cp0_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam int IM_LSB  = 10;
  localparam int IM_MSB  = 15;
  localparam int EXL_BIT = 1;
  localparam int IE_BIT  = 0;
  localparam int BD_BIT  = 31;
  localparam int IP_LSB  = 10;
  localparam int IP_MSB  = 15;
  localparam int EXC_LSB = 2;
  localparam int EXC_MSB = 6;

  typedef enum logic [4:0] {
    EXC_INT     = 5'd0,
    EXC_ADEL    = 5'd4,
    EXC_ADES    = 5'd5,
    EXC_SYSCALL = 5'd8,
    EXC_RI      = 5'd10,
    EXC_OV      = 5'd12
  } exc_code_e;

  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

endpackage

// File: rtl/cp0_int_arb.sv
// Combinational exception/interrupt arbiter: decides whether the M-stage
// victim is trapped and which ExcCode is recorded.
module cp0_int_arb
  import cp0_pkg::*;
(
  input  logic       i_ie,
  input  logic       i_exl,
  input  logic [5:0] i_im,
  input  logic [5:0] i_hw_int,
  input  logic [4:0] i_exc_code,
  output logic       o_int_req,
  output logic       o_exc_req,
  output logic       o_req,
  output logic [4:0] o_exc_code_sel
);

  assign o_int_req = i_ie & ~i_exl & (|(i_hw_int & i_im));
  assign o_exc_req = (i_exc_code != 5'd0) & ~i_exl;
  assign o_req     = o_int_req | o_exc_req;

  // Interrupt wins over a synchronous exception in the same cycle.
  assign o_exc_code_sel = o_int_req ? EXC_INT : i_exc_code;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor-0 for the M stage: SR/Cause/EPC/PRId, exception request and
// mfc0 read data. Optional macro CP0_EPC_FWD_EN forwards in-flight mtc0 EPC.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID_VAL   = 32'h2023_0707,
  parameter logic [31:0] HANDLER_PC = cp0_pkg::HANDLER_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [4:0]  exc_code_in,
  input  logic [5:0]  hw_int,
  input  logic        exl_clr,
  output logic [31:0] epc_out,
  output logic        req
);

  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exccode;
  logic [31:0] r_epc;

  logic        w_int_req;
  logic        w_exc_req;
  logic        w_req;
  logic [4:0]  w_exc_code_sel;
  logic [31:0] w_sr;
  logic [31:0] w_cause;
  logic        w_wr_sr;
  logic        w_wr_epc;

  cp0_int_arb u_arb (
    .i_ie           (r_ie),
    .i_exl          (r_exl),
    .i_im           (r_im),
    .i_hw_int       (hw_int),
    .i_exc_code     (exc_code_in),
    .o_int_req      (w_int_req),
    .o_exc_req      (w_exc_req),
    .o_req          (w_req),
    .o_exc_code_sel (w_exc_code_sel)
  );

  assign req      = w_req;
  assign w_wr_sr  = we & (cp0_addr == REG_SR);
  assign w_wr_epc = we & (cp0_addr == REG_EPC);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_im      <= '0;
      r_exl     <= 1'b0;
      r_ie      <= 1'b0;
      r_bd      <= 1'b0;
      r_ip      <= '0;
      r_exccode <= '0;
      r_epc     <= '0;
    end else begin
      r_ip <= hw_int;
      if (w_req) begin
        r_exl     <= 1'b1;
        r_exccode <= w_exc_code_sel;
        r_bd      <= bd_in;
        r_epc     <= bd_in ? (vpc - 32'd4) : vpc;
      end else begin
        if (w_wr_sr) begin
          r_im  <= cp0_wdata[IM_MSB:IM_LSB];
          r_exl <= cp0_wdata[EXL_BIT];
          r_ie  <= cp0_wdata[IE_BIT];
        end
        if (w_wr_epc) r_epc <= cp0_wdata;
        // Placed after the mtc0 SR write so eret's EXL clear takes priority.
        if (exl_clr) r_exl <= 1'b0;
      end
    end
  end

  always_comb begin
    w_sr                  = '0;
    w_sr[IM_MSB:IM_LSB]   = r_im;
    w_sr[EXL_BIT]         = r_exl;
    w_sr[IE_BIT]          = r_ie;
    w_cause               = '0;
    w_cause[BD_BIT]       = r_bd;
    w_cause[IP_MSB:IP_LSB]   = r_ip;
    w_cause[EXC_MSB:EXC_LSB] = r_exccode;
  end

  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      REG_SR:    cp0_rdata = w_sr;
      REG_CAUSE: cp0_rdata = w_cause;
      REG_EPC:   cp0_rdata = r_epc;
      REG_PRID:  cp0_rdata = PRID_VAL;
      default:   cp0_rdata = '0;
    endcase
  end

`ifdef CP0_EPC_FWD_EN
  assign epc_out = (w_wr_epc & ~w_req) ? cp0_wdata : r_epc;
`else
  assign epc_out = r_epc;
`endif

endmodule
